lane_engine: RTL and testbench

Parametrised multi-lane object engine that generalises the fixed four-lane car and lilypad rows into one block. It serves NUM_LANES lanes of OBJS_PER_LANE evenly spaced objects, each lane with its own speed, direction, Y position and ride flag. A sequential per-lane sweep, triggered once per frame by the VGA vertical sync, moves each lane in quarter-pixel steps with horizontal wrap-around. The block publishes frame-stable object X positions, per-lane frog hit flags and the ride displacement to the frog, color mapper and game control logic.

---
 rtl/lane_engine.sv | 192 +++++++++++++++++++
 tb/tb_lane_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_engine.sv
// Multi-lane object engine: per-frame sequential lane sweep with quarter-pixel motion,
// wrap-around, frog collision and ride displacement, published through frame-stable shadows.
module lane_engine #(
   parameter int NUM_LANES     = 4,
   parameter int OBJS_PER_LANE = 4,
   parameter int COORD_W       = 11,
   parameter int SCREEN_W      = 640,
   parameter int PITCH         = 160,
   parameter int OBJ_W         = 40,
   parameter int OBJ_H         = 40,
   parameter int SPEED_W       = 5,
   parameter int RIDE_W        = SPEED_W - 2 + 2
) (
   input  logic                                        Clk,
   input  logic                                        Reset,
   input  logic                                        vs,
   input  logic                                        pause,
   input  logic [NUM_LANES*SPEED_W-1:0]                lane_speed,
   input  logic [NUM_LANES-1:0]                        lane_dir,
   input  logic [NUM_LANES*COORD_W-1:0]                lane_y,
   input  logic [NUM_LANES-1:0]                        lane_ride,
   input  logic [COORD_W-1:0]                          frog_x,
   input  logic [COORD_W-1:0]                          frog_y,
   input  logic [COORD_W-1:0]                          frog_w,
   input  logic [COORD_W-1:0]                          frog_h,
   output logic [NUM_LANES*OBJS_PER_LANE*COORD_W-1:0]  obj_x,
   output logic [NUM_LANES-1:0]                        hit,
   output logic signed [RIDE_W-1:0]                    ride_dx,
   output logic                                        ride_valid,
   output logic                                        done,
   output logic                                        overrun
);

   localparam int POS_W = COORD_W + 2;
   localparam int CW1   = COORD_W + 1;
   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [POS_W:0]               POS_MAX = (POS_W+1)'(SCREEN_W * 4);
   localparam logic signed [COORD_W+1:0]    SCR_S   = (COORD_W+2)'(SCREEN_W);

   typedef enum logic [1:0] {IDLE, SWEEP, CHECK, COMMIT} state_t;

   // One conditional add/subtract keeps the position inside [0, SCREEN_W*4).
   function automatic logic [POS_W-1:0] step_wrap(input logic [POS_W-1:0] p,
                                                  input logic [SPEED_W-1:0] s,
                                                  input logic dir);
      logic [POS_W:0] sum;
      if (dir) begin
         sum = {1'b0, p} + (POS_W+1)'(s);
         if (sum >= POS_MAX) sum = sum - POS_MAX;
      end else begin
         sum = {1'b0, p} - (POS_W+1)'(s);
         if (sum[POS_W]) sum = sum + POS_MAX;
      end
      return sum[POS_W-1:0];
   endfunction

   function automatic logic [CW1-1:0] wrap_x(input logic [CW1-1:0] x);
      return (x >= CW1'(SCREEN_W)) ? x - CW1'(SCREEN_W) : x;
   endfunction

   function automatic logic signed [RIDE_W-1:0] ride_delta(input logic [COORD_W-1:0] o,
                                                           input logic [COORD_W-1:0] n,
                                                           input logic dir);
      logic signed [COORD_W+1:0] d;
      d = $signed({2'b00, n}) - $signed({2'b00, o});
      if (dir && (n < o)) d = d + SCR_S;
      if (!dir && (n > o)) d = d - SCR_S;
      return $signed(d[RIDE_W-1:0]);
   endfunction

   state_t                 state;
   logic                   vs_q;
   logic [IDX_W-1:0]       idx;
   logic [POS_W-1:0]       pos [NUM_LANES];
   logic                   tick;
   logic [POS_W-1:0]       pos_p0;
   logic                   vld_p1;
   logic [IDX_W-1:0]       lane_p1;
   logic [COORD_W-1:0]     old_p1;
   logic [COORD_W-1:0]     new_p1;
   logic                   dir_p1;
   logic                   hit_p1;
   logic [NUM_LANES-1:0]   hit_acc;
   logic                   ride_found;
   logic signed [RIDE_W-1:0] ride_acc;
   logic [NUM_LANES*OBJS_PER_LANE*COORD_W-1:0] obj_x_next;
   logic [CW1-1:0]         ly, fx, fy, fw, fh, ox, oe, tx;
   logic                   v_ovl, h_ovl;

   assign tick   = vs && !vs_q && !pause;
   assign pos_p0 = step_wrap(pos[idx], lane_speed[idx*SPEED_W +: SPEED_W], lane_dir[idx]);

   // Stage p1: collision of the lane moved in the previous cycle, against its new position.
   always_comb begin
      ly    = CW1'(lane_y[lane_p1*COORD_W +: COORD_W]);
      fx    = CW1'(frog_x);
      fy    = CW1'(frog_y);
      fw    = CW1'(frog_w);
      fh    = CW1'(frog_h);
      ox    = '0;
      oe    = '0;
      v_ovl = (fy < ly + CW1'(OBJ_H)) && (ly < fy + fh);
      h_ovl = 1'b0;
      for (int k = 0; k < OBJS_PER_LANE; k++) begin
         ox = wrap_x(CW1'(new_p1) + CW1'(k * PITCH));
         oe = ox + CW1'(OBJ_W);
         if ((fx < oe) && (ox < fx + fw)) h_ovl = 1'b1;
         if ((oe > CW1'(SCREEN_W)) && (fx < oe - CW1'(SCREEN_W)) && (fw != '0)) h_ovl = 1'b1;
      end
      hit_p1 = vld_p1 && v_ovl && h_ovl;
   end

   always_comb begin
      obj_x_next = '0;
      tx         = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         for (int k = 0; k < OBJS_PER_LANE; k++) begin
            tx = wrap_x(CW1'(pos[i][POS_W-1:2]) + CW1'(k * PITCH));
            obj_x_next[(i*OBJS_PER_LANE+k)*COORD_W +: COORD_W] = tx[COORD_W-1:0];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         vs_q       <= 1'b0;
         idx        <= '0;
         vld_p1     <= 1'b0;
         lane_p1    <= '0;
         old_p1     <= '0;
         new_p1     <= '0;
         dir_p1     <= 1'b0;
         hit_acc    <= '0;
         ride_found <= 1'b0;
         ride_acc   <= '0;
         hit        <= '0;
         ride_dx    <= '0;
         ride_valid <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            pos[i] <= '0;
            for (int k = 0; k < OBJS_PER_LANE; k++)
               obj_x[(i*OBJS_PER_LANE+k)*COORD_W +: COORD_W] <= COORD_W'(k * PITCH);
         end
      end else begin
         vs_q   <= vs;
         done   <= 1'b0;
         vld_p1 <= 1'b0;
         if (tick && (state != IDLE)) overrun <= 1'b1;
         if (vld_p1) begin
            hit_acc[lane_p1] <= hit_p1;
            if (hit_p1 && lane_ride[lane_p1] && !ride_found) begin
               ride_found <= 1'b1;
               ride_acc   <= ride_delta(old_p1, new_p1, dir_p1);
            end
         end
         case (state)
            IDLE: if (tick) begin
               state      <= SWEEP;
               idx        <= '0;
               hit_acc    <= '0;
               ride_found <= 1'b0;
               ride_acc   <= '0;
            end
            // Stage p0: advance one lane per cycle.
            SWEEP: begin
               pos[idx] <= pos_p0;
               lane_p1  <= idx;
               old_p1   <= pos[idx][POS_W-1:2];
               new_p1   <= pos_p0[POS_W-1:2];
               dir_p1   <= lane_dir[idx];
               vld_p1   <= 1'b1;
               if (idx == IDX_W'(NUM_LANES - 1)) state <= CHECK;
               else idx <= idx + 1'b1;
            end
            CHECK: state <= COMMIT;
            COMMIT: begin
               obj_x      <= obj_x_next;
               hit        <= hit_acc;
               ride_valid <= ride_found;
               ride_dx    <= ride_found ? ride_acc : '0;
               done       <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lane_engine.sv
// Directed bench for lane_engine: motion, wrap, split-object hits, ride lane, pause,
// overrun and mid-sweep reset, with hand-computed expectations.
module tb_lane_engine;

   logic              Clk = 1'b0;
   logic              Reset, vs, pause;
   logic [19:0]       lane_speed;
   logic [3:0]        lane_dir, lane_ride;
   logic [43:0]       lane_y;
   logic [10:0]       frog_x, frog_y, frog_w, frog_h;
   logic [175:0]      obj_x;
   logic [3:0]        hit;
   logic signed [4:0] ride_dx;
   logic              ride_valid, done, overrun;

   int checks   = 0;
   int failures = 0;
   int lat, cnt;

   lane_engine dut (
      .Clk(Clk), .Reset(Reset), .vs(vs), .pause(pause),
      .lane_speed(lane_speed), .lane_dir(lane_dir), .lane_y(lane_y), .lane_ride(lane_ride),
      .frog_x(frog_x), .frog_y(frog_y), .frog_w(frog_w), .frog_h(frog_h),
      .obj_x(obj_x), .hit(hit), .ride_dx(ride_dx), .ride_valid(ride_valid),
      .done(done), .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] ox(input int lane, input int k);
      return obj_x[(lane*4+k)*11 +: 11];
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int i, input int spd, input logic dir);
      lane_speed[i*5 +: 5] = 5'(spd);
      lane_dir[i]          = dir;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) begin @(posedge Clk); #1; end
      Reset = 1'b0;
   endtask

   // Pulses vs and returns the number of edges until done is seen (0 if never).
   task automatic run_frame(output int l);
      vs = 1'b1;
      l  = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge Clk); #1;
         if (n == 1) vs = 1'b0;
         if (done) begin l = n; break; end
      end
   endtask

   task automatic count_done(input int cycles, output int c);
      c = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge Clk); #1;
         if (done) c++;
      end
   endtask

   initial begin
      vs = 1'b0; pause = 1'b0; Reset = 1'b0;
      lane_speed = '0; lane_dir = '0; lane_ride = '0;
      lane_y = {11'd200, 11'd300, 11'd100, 11'd40};
      frog_x = 11'd0; frog_y = 11'd1000; frog_w = 11'd16; frog_h = 11'd16;
      @(posedge Clk); #1;

      do_reset();
      check("rst_obj0", ox(0,0), 0);
      check("rst_obj1", ox(0,1), 160);
      check("rst_obj2", ox(0,2), 320);
      check("rst_obj3", ox(0,3), 480);
      check("rst_hit", hit, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_ride", {ride_valid, ride_dx}, 0);

      set_lane(0, 4, 1'b1);
      run_frame(lat);
      check("l0_f1_lat", lat, 7);
      check("l0_f1_x0", ox(0,0), 1);
      check("l0_f1_x1", ox(0,1), 161);
      @(posedge Clk); #1;
      check("done_pulse_len", done, 0);
      run_frame(lat);
      check("l0_f2_lat", lat, 7);
      check("l0_f2_x0", ox(0,0), 2);
      run_frame(lat);
      check("l0_f3_lat", lat, 7);
      check("l0_f3_x0", ox(0,0), 3);

      set_lane(0, 0, 1'b0);
      set_lane(1, 1, 1'b0);
      run_frame(lat);
      check("l1_f1_x0", ox(1,0), 639);
      check("l1_f1_l0", ox(0,0), 3);
      check("l1_f1_hit", hit, 0);
      repeat (3) run_frame(lat);
      check("l1_f4_x0", ox(1,0), 639);
      run_frame(lat);
      check("l1_f5_x0", ox(1,0), 638);
      check("l1_f5_x1", ox(1,1), 158);

      set_lane(1, 0, 1'b0);
      do_reset();
      set_lane(3, 20, 1'b0);
      repeat (4) run_frame(lat);
      set_lane(3, 0, 1'b0);
      frog_x = 11'd5; frog_y = 11'd200;
      run_frame(lat);
      check("split_x0", ox(3,0), 620);
      check("split_hit", hit, 4'b1000);
      check("split_noride", ride_valid, 0);
      frog_x = 11'd30;
      run_frame(lat);
      check("split_miss", hit, 0);

      lane_ride[2] = 1'b1;
      set_lane(2, 8, 1'b0);
      frog_x = 11'd170; frog_y = 11'd300;
      run_frame(lat);
      check("ride_wrap_x0", ox(2,0), 638);
      check("ride_wrap_hit", hit, 4'b0100);
      check("ride_wrap_vld", ride_valid, 1);
      check("ride_wrap_dx", ride_dx, -2);
      run_frame(lat);
      check("ride_left_vld", ride_valid, 1);
      check("ride_left_dx", ride_dx, -2);
      set_lane(2, 8, 1'b1);
      run_frame(lat);
      check("ride_right_dx", ride_dx, 2);
      frog_y = 11'd1000;
      run_frame(lat);
      check("ride_none_vld", ride_valid, 0);
      check("ride_none_dx", ride_dx, 0);
      check("ride_right_wrap_x0", ox(2,0), 0);

      set_lane(2, 8, 1'b0);
      pause = 1'b1;
      vs = 1'b1;
      @(posedge Clk); #1;
      vs = 1'b0;
      count_done(12, cnt);
      pause = 1'b0;
      check("pause_done", cnt, 0);
      check("pause_x0", ox(2,0), 0);
      run_frame(lat);
      check("after_pause_x0", ox(2,0), 638);

      cnt = 0;
      vs  = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge Clk); #1;
         if (n == 1) vs = 1'b0;
         if (n == 3) vs = 1'b1;
         if (n == 4) vs = 1'b0;
         if (done) cnt++;
      end
      check("ovr_flag", overrun, 1);
      check("ovr_one_done", cnt, 1);
      check("ovr_x0", ox(2,0), 636);
      run_frame(lat);
      check("ovr_sticky", overrun, 1);
      check("ovr_next_lat", lat, 7);
      check("ovr_next_x0", ox(2,0), 634);

      vs = 1'b1;
      @(posedge Clk); #1;
      vs = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      check("midrst_x0", ox(2,0), 0);
      check("midrst_x1", ox(2,1), 160);
      check("midrst_overrun", overrun, 0);
      count_done(12, cnt);
      check("midrst_no_done", cnt, 0);
      run_frame(lat);
      check("midrst_lat", lat, 7);
      check("midrst_pos", ox(2,0), 638);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
